mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction cache and the data cache.
- Each cache raises a request and waits on its own wait line. The arbiter grants one requester at a time, drives the RAM, and returns the loaded word.
- Data requests have priority. A starvation counter guarantees the instruction side forward progress.
- Sits between the icache/dcache miss paths and the RAM model in the CPU top level.

Parameters:
STARVE_LIMIT, 4, consecutive dcache grants allowed while iREN is pending before icache is forced (range 1..15)

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
iREN  input  1  icache read request
iaddr  input  32  icache word address
iwait  output  1  icache wait; low for exactly the completing cycle
iload  output  32  instruction word, valid when iwait low
dREN  input  1  dcache read request
dWEN  input  1  dcache write request
daddr  input  32  dcache word address
dstore  input  32  dcache write data
dwait  output  1  dcache wait; low for exactly the completing cycle
dload  output  32  data word, valid when dwait low and dREN
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clocking: one clock CLK. Reset nRST is asynchronous, active-low.
- Reset state: IDLE, starve counter 0.
- Reset output values:
  - iwait = dwait = 1
  - iload = dload = 0
  - ramREN = ramWEN = 0
  - ramaddr = ramstore = 0
- Wait lines are combinational and default to 1 in every state. Loads default to 0.
- States: IDLE, IGRANT, DGRANT. The state register updates on posedge CLK.
- IDLE:
  - Drives nothing to the RAM.
  - If (dREN|dWEN) and not (iREN and starve==STARVE_LIMIT), next state is DGRANT.
  - Else if iREN, next state is IGRANT.
  - Else stays in IDLE.
- IGRANT:
  - ramREN=1, ramaddr=iaddr.
  - If ramstate==ACCESS: iwait=0, iload=ramload, next state IDLE.
- DGRANT:
  - ramWEN=dWEN, ramREN=dREN & ~dWEN, ramaddr=daddr, ramstore=dstore.
  - If ramstate==ACCESS: dwait=0, dload=ramload (0 on a write), next state IDLE.
- RAM status handling: BUSY, FREE and ERROR while granted mean keep driving the request and stay in state. ERROR is treated as a retry.
- Request withdrawn while granted (granted REN/WEN low):
  - Drop the RAM enables the same cycle.
  - Wait stays 1.
  - Next state IDLE. No completion is reported.
- Minimum latency: a request seen in IDLE at cycle n puts the RAM request out at n+1. With the RAM answering ACCESS immediately, wait is low at n+1.
- Back-to-back: the earliest next grant starts 2 cycles after a completion (completion cycle, then an IDLE cycle).
- Starve counter (4 bits):
  - Increments on each IDLE→DGRANT transition while iREN=1, saturating at STARVE_LIMIT.
  - Clears to 0 on IDLE→IGRANT.
  - Also clears when iREN=0 in IDLE.
- A simultaneous dREN and dWEN is illegal. The write takes precedence.
- Grants are never preempted. A pending higher-priority request waits for the current transaction to finish.
- Address and data are not latched. The requester must hold them stable until its wait drops.

Decomposition:
- cpu_types_pkg holds:
  - the ramstate_t enum (FREE, BUSY, ACCESS, ERROR)
  - word_t (32 bits)
  - the arbiter state_t enum {IDLE, IGRANT, DGRANT}
- Single module, no sub-module. The starve counter is inline.
- The top level binds the caches_if icache/dcache signals onto these ports.

Test Plan:
- Reset mid-transaction:
  - Stimulus: assert nRST=0 while in DGRANT.
  - Response: all outputs return to their reset values immediately (asynchronous). State is IDLE, counter 0.
- Single icache read:
  - Stimulus: iREN=1, iaddr=0x0000_0040; ramstate BUSY for 2 cycles then ACCESS with ramload=0x2001_0005.
  - Response: ramREN=1 and ramaddr=0x40 from cycle 1. iwait low only in cycle 3, with iload=0x2001_0005.
- Simultaneous requests:
  - Stimulus: iREN=1 and dWEN=1 in the same cycle; daddr=0x100, dstore=0xDEAD_BEEF; immediate ACCESS.
  - Response: dcache is served first (ramWEN=1, ramstore=0xDEADBEEF, dwait low at cycle 1). The icache grant follows and iwait is low at cycle 3.
- Starvation:
  - Stimulus: iREN held at 1 while dREN is re-asserted every IDLE cycle; STARVE_LIMIT=4.
  - Response: exactly 4 dcache completions, then one icache completion, then dcache resumes.
- Withdrawal:
  - Stimulus: dREN dropped while in DGRANT with ramstate=BUSY.
  - Response: ramREN=0 the same cycle, dwait stays 1, next state IDLE, pending iREN granted the following cycle.
- ERROR retry:
  - Stimulus: ramstate=ERROR for 3 cycles, then ACCESS, during IGRANT.
  - Response: ramREN stays 1 throughout, iwait is low exactly once (the ACCESS cycle), no dwait pulse.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake status, data word and the
// memory arbiter state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RAM between icache and dcache; dcache has
// priority, bounded by a starvation counter that eventually forces an icache grant.
//
// state  | meaning
// IDLE   | RAM untouched, choose next requester
// IGRANT | icache owns the RAM until ACCESS or withdrawal
// DGRANT | dcache owns the RAM until ACCESS or withdrawal
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    state_t              state, next_state;
    logic [STARVE_W-1:0] starve, next_starve;
    logic                dreq;
    logic                force_i;
    logic                access;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            state  <= next_state;
            starve <= next_starve;
        end
    end

    always_comb begin
        dreq        = dREN | dWEN;
        force_i     = iREN && (starve == LIMIT);
        access      = (ramstate == ACCESS);
        next_state  = state;
        next_starve = starve;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;

        case (state)
            IDLE: begin
                if (dreq && !force_i) begin
                    next_state = DGRANT;
                    if (iREN && (starve < LIMIT))
                        next_starve = starve + 1'b1;
                end else if (iREN) begin
                    next_state  = IGRANT;
                    next_starve = '0;
                end
                if (!iREN)
                    next_starve = '0;
            end

            IGRANT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (access) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        next_state = IDLE;
                    end
                end else begin
                    next_state = IDLE;
                end
            end

            DGRANT: begin
                // A write wins over a simultaneous read request.
                if (dreq) begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (access) begin
                        dwait      = 1'b0;
                        dload      = dWEN ? '0 : ramload;
                        next_state = IDLE;
                    end
                end else begin
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

endmodule
